// File: rtl/imem_loader.sv
// Instruction memory download controller and RAM port arbiter.
// Packs a byte stream into little-endian words and stalls the core while loading.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [31:0]       ram_wrdata,
   output logic              cpu_stall,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_e;

   localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [31:0]         shift_word_q, shift_word_d;
   logic                err_q, err_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                too_big;
   logic                last_word;

   assign too_big   = word_count > MAX_CNT;
   assign last_word = {1'b0, wr_ptr_q} == (count_q - ONE_CNT);
   assign err       = err_q;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      byte_cnt_d   = byte_cnt_q;
      shift_word_d = shift_word_q;
      err_d        = err_q;
      count_d      = count_q;
      byte_ready   = 1'b0;
      ram_wren     = 1'b0;
      busy         = 1'b1;
      cpu_stall    = 1'b1;
      done         = 1'b0;
      ram_addr     = wr_ptr_q;
      ram_wrdata   = shift_word_q;
      unique case (state_q)
         S_IDLE: begin
            busy      = 1'b0;
            cpu_stall = 1'b0;
            ram_addr  = fetch_addr;
            if (start) begin
               err_d      = too_big;
               count_d    = too_big ? MAX_CNT : word_count;
               wr_ptr_d   = '0;
               byte_cnt_d = '0;
               if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            byte_ready = 1'b1;
            if (abort) begin
               state_d    = S_IDLE;
               byte_cnt_d = '0;
            end else if (byte_valid) begin
               shift_word_d[8*byte_cnt_q +: 8] = byte_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // abort suppresses the write that would land this cycle
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               ram_wren = 1'b1;
               if (last_word) begin
                  state_d = S_DONE;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  state_d  = S_LOAD;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         byte_cnt_q   <= '0;
         shift_word_q <= '0;
         err_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_word_q <= shift_word_d;
         err_q        <= err_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-stream model with per-cycle output comparison.
// Directed scenarios plus randomized loads with backpressure and aborts.
module tb_imem_loader;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [AW:0]   word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic [AW-1:0] fetch_addr;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [31:0]   ram_wrdata;
   logic          cpu_stall;
   logic          busy;
   logic          done;
   logic          err;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .fetch_addr (fetch_addr),
      .ram_addr   (ram_addr),
      .ram_wren   (ram_wren),
      .ram_wrdata (ram_wrdata),
      .cpu_stall  (cpu_stall),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model: a download is a count of words and a byte stream
   bit          chk_en = 0;
   bit          m_active = 0;
   bit          m_wpend = 0;
   bit          m_dpend = 0;
   bit          m_err = 0;
   int          m_k = 0;
   int          m_words = 0;
   int          m_nb = 0;
   logic [31:0] m_word = '0;

   // observed writes
   logic [31:0] dut_mem [DEPTH];
   int          wr_cnt;
   int          last_addr;
   int          done_cnt;
   int          done_cyc;
   int          stall_cnt;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      int wc;
      wc = int'(word_count);
      cyc++;
      if (!rst_n) begin
         m_active = 0;
         m_wpend  = 0;
         m_dpend  = 0;
         m_err    = 0;
         m_nb     = 0;
         m_word   = '0;
         chk_en   = 1;
      end else if (!m_active) begin
         if (start) begin
            m_k      = (wc > DEPTH) ? DEPTH : wc;
            m_err    = wc > DEPTH;
            m_active = 1;
            m_words  = 0;
            m_nb     = 0;
            m_dpend  = (m_k == 0);
         end
      end else if (m_dpend) begin
         m_dpend  = 0;
         m_active = 0;
      end else if (abort) begin
         m_active = 0;
         m_wpend  = 0;
         m_nb     = 0;
      end else if (m_wpend) begin
         m_wpend = 0;
         m_words++;
         if (m_words == m_k) m_dpend = 1;
      end else if (byte_valid) begin
         m_word[8*m_nb +: 8] = byte_data;
         m_nb++;
         if (m_nb == 4) begin
            m_nb    = 0;
            m_wpend = 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // single compare process, sampled mid-cycle
   initial forever begin
      logic [AW-1:0] e_addr;
      bit            e_wren;
      @(negedge clk);
      if (chk_en) begin
         e_wren = m_wpend && !abort;
         if (!m_active) e_addr = fetch_addr;
         else if (m_dpend) e_addr = (m_k == 0) ? '0 : AW'(m_k - 1);
         else e_addr = AW'(m_words);
         chk("byte_ready", 32'(byte_ready),
             32'(m_active && !m_wpend && !m_dpend));
         chk("ram_wren", 32'(ram_wren), 32'(e_wren));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr));
         chk("busy", 32'(busy), 32'(m_active));
         chk("cpu_stall", 32'(cpu_stall), 32'(m_active));
         chk("done", 32'(done), 32'(m_dpend));
         chk("err", 32'(err), 32'(m_err));
         if (e_wren) chk("ram_wrdata", ram_wrdata, m_word);
         if (ram_wren === 1'b1) begin
            dut_mem[ram_addr] = ram_wrdata;
            wr_cnt++;
            last_addr = int'(ram_addr);
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cpu_stall === 1'b1) stall_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wr_cnt    = 0;
      last_addr = -1;
      done_cnt  = 0;
      done_cyc  = -1;
      stall_cnt = 0;
   endtask

   // mode 0: no gaps, 1: valid every other cycle, 2: random valid
   task automatic load(input int wc, input logic [7:0] bq_in[$],
                       input int mode, input int abort_after,
                       input bit stray, output int s_cyc);
      logic [7:0] bq[$];
      int  sent;
      int  guard;
      bit  v;
      bit  acc;
      bq = bq_in;
      sent = 0;
      guard = 0;
      step();
      start      = 1'b1;
      word_count = (AW+1)'(wc);
      clear_mon();
      s_cyc = cyc;
      step();
      start = 1'b0;
      while (m_active && guard < 20000) begin
         unique case (mode)
            0: v = 1;
            1: v = cyc[0];
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         v = v && (bq.size() > 0);
         abort = (abort_after >= 0 && sent >= abort_after);
         start = stray && ($urandom_range(0, 3) == 0);
         if (stray) word_count = (AW+1)'($urandom_range(0, 15));
         fetch_addr = AW'($urandom);
         byte_valid = v;
         byte_data  = v ? bq[0] : 8'($urandom);
         @(negedge clk);
         acc = byte_valid && byte_ready && !abort;
         step();
         if (acc) begin
            void'(bq.pop_front());
            sent++;
         end
         guard++;
      end
      if (guard >= 20000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL load_timeout: got busy after %0d cycles expected idle",
                  guard);
      end
      byte_valid = 1'b0;
      abort      = 1'b0;
      start      = 1'b0;
   endtask

   initial begin
      logic [7:0] bq[$];
      int s;
      int nw;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      fetch_addr = '0;
      clear_mon();
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // two-word load, no gaps
      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};
      load(2, bq, 0, -1, 0, s);
      chk("two_word_mem0", dut_mem[0], 32'h0000_0013);
      chk("two_word_mem1", dut_mem[1], 32'h0000_10B7);
      chk("two_word_writes", wr_cnt, 2);
      chk("two_word_done_lat", done_cyc - s, 11);
      chk("two_word_stall_cycles", stall_cnt, 11);
      step();

      // same load with toggling byte_valid
      dut_mem[0] = '0;
      dut_mem[1] = '0;
      load(2, bq, 1, -1, 0, s);
      chk("bp_mem0", dut_mem[0], 32'h0000_0013);
      chk("bp_mem1", dut_mem[1], 32'h0000_10B7);
      chk("bp_writes", wr_cnt, 2);
      chk("bp_done_cnt", done_cnt, 1);

      // abort after six bytes of a four-word load
      bq.delete();
      for (int i = 0; i < 16; i++) bq.push_back(8'(i + 8'h40));
      load(4, bq, 0, 6, 0, s);
      chk("abort_writes", wr_cnt, 1);
      chk("abort_mem0", dut_mem[0], 32'h4342_4140);
      chk("abort_no_done", done_cnt, 0);
      @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'd0);
      bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      load(1, bq, 0, -1, 0, s);
      chk("post_abort_mem0", dut_mem[0], 32'hDEAD_BEEF);
      chk("post_abort_done", done_cnt, 1);

      // zero-word load
      bq.delete();
      load(0, bq, 0, -1, 0, s);
      chk("zero_done_lat", done_cyc - s, 1);
      chk("zero_writes", wr_cnt, 0);

      // oversized count clamps to full RAM
      for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom));
      load(11'h7FF, bq, 0, -1, 0, s);
      chk("clamp_err", 32'(err), 32'd1);
      chk("clamp_writes", wr_cnt, DEPTH);
      chk("clamp_last_addr", last_addr, 32'h3FF);
      chk("clamp_done", done_cnt, 1);
      bq = '{8'h01, 8'h02, 8'h03, 8'h04};
      load(1, bq, 0, -1, 0, s);
      chk("err_cleared", 32'(err), 32'd0);

      // stray starts while loading
      bq.delete();
      for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
      load(3, bq, 0, -1, 1, s);
      chk("stray_writes", wr_cnt, 3);
      chk("stray_last_addr", last_addr, 2);

      // start with abort in idle: start wins
      step();
      abort = 1'b1;
      bq = '{8'h11, 8'h22, 8'h33, 8'h44};
      load(1, bq, 0, -1, 0, s);
      chk("start_abort_mem0", dut_mem[0], 32'h4433_2211);

      // reset during a download
      step();
      start      = 1'b1;
      word_count = 11'd4;
      step();
      start      = 1'b0;
      byte_valid = 1'b1;
      repeat (5) step();
      byte_valid = 1'b0;
      rst_n      = 1'b0;
      fetch_addr = 10'h05A;
      clear_mon();
      step();
      @(negedge clk);
      chk("rst_ram_addr", 32'(ram_addr), 32'h05A);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(byte_ready), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      chk("rst_no_writes", wr_cnt, 0);

      // randomized loads
      for (int t = 0; t < 40; t++) begin
         nw = $urandom_range(0, 9);
         bq.delete();
         for (int i = 0; i < 4 * nw; i++) bq.push_back(8'($urandom));
         load(nw, bq, $urandom_range(0, 2),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4 * nw) : -1,
              $urandom_range(0, 1), s);
         repeat ($urandom_range(0, 3)) step();
      end

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
